// File: rtl/segrw_pkg.sv
// Shared definitions for the segment read/write initiator and responder.
// Holds the FSM encoding, request direction constants and default widths.
package segrw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } segrw_state_t;

  localparam logic SEGRW_WR = 1'b1;
  localparam logic SEGRW_RD = 1'b0;

  localparam int SEGRW_NELEMS = 127;
  localparam int SEGRW_AWIDTH = 7;
  localparam int SEGRW_DWIDTH = 7;
  localparam int SEGRW_MAXOUT = 4;

  // Next address inside a segment of n words, wrapping at the top.
  function automatic int segrw_wrap_inc(input int a, input int n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/segrw_resp_fifo.sv
// Read-response FIFO: depth entries of width bits, synchronous reset, occupancy out.
// Push and pop may coincide at any fill level; the caller guarantees no overflow.
module segrw_resp_fifo #(
  parameter int depth = 4,
  parameter int width = 7,
  parameter int cw    = $clog2(depth + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [width-1:0] i_push_d,
  input  logic             i_pop,
  output logic [width-1:0] o_head_d,
  output logic [cw-1:0]    o_count
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] r_mem [depth];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [cw-1:0]    r_cnt;

  // depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wp] <= i_push_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= f_inc(r_wp);
      if (i_pop)  r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + cw'(i_push) - cw'(i_pop);
    end
  end

  assign o_head_d = r_mem[r_rp];
  assign o_count  = r_cnt;

endmodule

// File: rtl/segrw_initiator.sv
// Converts block read/write commands into per-word segment requests.
// Optional SEGRW_INITIATOR_STATS_EN adds saturating wr_count/rd_count outputs.
module segrw_initiator
  import segrw_pkg::*;
#(
  parameter int nelems = SEGRW_NELEMS,
  parameter int awidth = SEGRW_AWIDTH,
  parameter int dwidth = SEGRW_DWIDTH,
  parameter int maxout = SEGRW_MAXOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [awidth-1:0] cmd_base,
  input  logic [awidth:0]   cmd_len,
  input  logic              cmd_write,
  input  logic [dwidth-1:0] wdata_d,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [awidth-1:0] addr_d,
  output logic [dwidth-1:0] dataW_d,
  output logic              write_d,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic [dwidth-1:0] dataR_d,
  input  logic              dataR_valid,
  output logic [dwidth-1:0] rdata_d,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              busy,
  output logic              done,
  output logic              proto_err
`ifdef SEGRW_INITIATOR_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);
  localparam int CW = $clog2(maxout + 1);

  segrw_state_t      r_state, w_state_nxt;
  logic [awidth-1:0] r_addr;
  logic [awidth:0]   r_rem;
  logic [CW-1:0]     r_out;
  logic              r_done;
  logic              r_perr;
  logic [1:0]        r_mask;
  logic [CW-1:0]     w_cnt;
  logic [dwidth-1:0] w_head;
  logic              w_fin, w_cmd_fire, w_req_fire, w_rd_issue, w_push, w_pop, w_mask;

  assign w_mask     = (r_mask != 2'd0);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_req_fire = req_valid && req_ready;
  assign w_rd_issue = w_req_fire && (r_state == READ);
  // Responses only count against a read we actually issued since reset.
  assign w_push     = dataR_valid && !w_mask && (r_out != '0);
  assign w_pop      = rdata_valid && rdata_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    cmd_ready   = 1'b0;
    req_valid   = 1'b0;
    write_d     = SEGRW_RD;
    dataW_d     = '0;
    wdata_ready = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = !r_done;
        if (cmd_valid && !r_done) begin
          if (cmd_len == '0) w_fin = 1'b1;
          else w_state_nxt = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        req_valid   = wdata_valid;
        write_d     = SEGRW_WR;
        dataW_d     = wdata_d;
        wdata_ready = req_ready;
        if (w_req_fire && r_rem == (awidth+1)'(1)) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
        end
      end
      READ: begin
        // Credit: words in flight plus words buffered never exceed maxout.
        req_valid = (int'(r_out) + int'(w_cnt)) < maxout;
        if (w_req_fire && r_rem == (awidth+1)'(1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_out == '0 && w_cnt == '0) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_mask  <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin;
      if (w_mask) r_mask <= r_mask - 2'd1;
      if (w_cmd_fire) begin
        r_addr <= cmd_base;
        r_rem  <= cmd_len;
      end else if (w_req_fire) begin
        r_addr <= awidth'(segrw_wrap_inc(int'(r_addr), nelems));
        r_rem  <= r_rem - (awidth+1)'(1);
      end
      r_out <= r_out + CW'(w_rd_issue) - CW'(w_push);
      if (dataR_valid && !w_mask && r_out == '0) r_perr <= 1'b1;
    end
  end

  segrw_resp_fifo #(.depth(maxout), .width(dwidth), .cw(CW)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .i_push   (w_push),
    .i_push_d (dataR_d),
    .i_pop    (w_pop),
    .o_head_d (w_head),
    .o_count  (w_cnt)
  );

  assign addr_d      = r_addr;
  assign rdata_valid = (w_cnt != '0);
  assign rdata_d     = rdata_valid ? w_head : '0;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign proto_err   = r_perr;

`ifdef SEGRW_INITIATOR_STATS_EN
  logic [15:0] r_wr_cnt, r_rd_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_req_fire && r_state == WRITE && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_push && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end
  assign wr_count = r_wr_cnt;
  assign rd_count = r_rd_cnt;
`endif

endmodule

// File: doc/segrw_initiator.md
Name: segrw_initiator

Overview:
- Initiator for the segment read/write stream interface (addr / dataW / write request stream, dataR response stream).
- Accepts block commands (base, length, direction).
- Write commands: issues one request per word drawn from an input data stream.
- Read commands: issues sequential read requests and returns the responses, in order, on an output stream.
- Sits between streaming operators and a segment responder; converts bulk transfers into per-word segment requests.

Parameters:
- nelems, 127, segment size in words; addresses wrap within 0..nelems-1.
- awidth, 7, address width.
- dwidth, 7, data width.
- maxout, 4, maximum read words in flight plus buffered, with 2 <= maxout <= 16; also the response FIFO depth.

Ports:
- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_base  in  awidth  first address (must be < nelems).
- cmd_len  in  awidth+1  word count; 0 is legal.
- cmd_write  in  1  1 = write transfer, 0 = read transfer.
- wdata_d  in  dwidth  write source data.
- wdata_valid  in  1  write source data valid.
- wdata_ready  out  1  write source data consumed.
- addr_d  out  awidth  request address to segment.
- dataW_d  out  dwidth  request write data.
- write_d  out  1  request direction.
- req_valid  out  1  request offered.
- req_ready  in  1  segment accepts request.
- dataR_d  in  dwidth  read response data.
- dataR_valid  in  1  read response present; no backpressure possible.
- rdata_d  out  dwidth  read data to consumer.
- rdata_valid  out  1  read data valid.
- rdata_ready  in  1  consumer accepts read data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- proto_err  out  1  sticky: response arrived with no read outstanding.

Behaviour:
- Reset (synchronous, active-high):
  - State becomes IDLE.
  - Counters and FIFO are cleared.
  - All outputs are 0: req_valid, wdata_ready, rdata_valid, busy, done, proto_err, addr_d, dataW_d, write_d, rdata_d.
  - Reset mid-command aborts the command. Any responses still in flight are discarded and do not set proto_err for 2 cycles after reset.
- Handshakes:
  - Valid/ready on cmd, wdata, req and rdata.
  - A transfer occurs on a cycle where both signals are 1.
  - Once req_valid is asserted, addr_d, dataW_d and write_d are held stable until the transfer.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1, busy=0.
  - On command transfer, latch addr<=cmd_base and rem<=cmd_len.
  - cmd_len==0: done pulses next cycle, stay IDLE.
  - Otherwise go to WRITE if cmd_write=1, else READ.
- WRITE:
  - req_valid=wdata_valid, write_d=1, dataW_d=wdata_d, wdata_ready=req_ready (combinational pass-through, zero added latency).
  - Each transfer: addr advances, rem decrements.
  - On the transfer with rem==1: IDLE, done pulses next cycle.
- READ:
  - req_valid=1 when outstanding+fifo_count < maxout; write_d=0.
  - Each request transfer: outstanding++, addr advances, rem decrements.
  - After the last issue: DRAIN.
- Response path, all states:
  - dataR_valid pushes dataR_d into the FIFO and decrements outstanding.
  - Simultaneous issue and response in one cycle: outstanding is unchanged.
- FIFO output:
  - rdata_valid = FIFO not empty.
  - Pop on rdata transfer.
  - Push and pop in the same cycle are allowed at full and at empty.
  - Empty: the push goes in and the output is valid next cycle.
  - Overflow is impossible by credit rule.
- DRAIN: when outstanding==0 and the FIFO is empty, go to IDLE; done pulses next cycle.
- Address advance: addr==nelems-1 wraps to 0; otherwise addr+1.
- cmd_len is at most 2^awidth; lengths greater than nelems re-visit addresses in order.
- proto_err: dataR_valid with outstanding==0 and no FIFO push is ignored and sets proto_err; it clears only on reset.
- cmd_ready is 0 in all states except IDLE. A new command is accepted no earlier than the cycle after done.

Optional Feature:
- Macro SEGRW_INITIATOR_STATS_EN.
- Defined:
  - Adds outputs wr_count[15:0] and rd_count[15:0].
  - These count write request transfers and read response pushes.
  - They saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package segrw_pkg holds:
  - The state encoding constants IDLE/WRITE/READ/DRAIN.
  - Request direction constants: SEGRW_WR=1, SEGRW_RD=0.
  - Default width constants shared with the segment responder.
- One sub-module, segrw_resp_fifo:
  - Depth maxout, width dwidth.
  - Synchronous reset, count output.
- The top level holds the FSM, address/remaining counters and credit logic.

Test Plan:
- Write 5 words from base 3, data 10..14, req_ready held 1 -> addresses 3,4,5,6,7 in 5 consecutive cycles; done one cycle after the last transfer; readback via a responder model returns 10..14.
- Read 8 words from base 124, nelems=127, responder latency 3, rdata_ready=0 -> addresses 124,125,126,0 issued; issue stalls at 4 in flight+buffered; raising rdata_ready completes all 8 in order; done after the 8th pop.
- cmd_len=0 -> no req_valid; done pulses one cycle after acceptance; busy stays 0.
- Write with wdata_valid toggling 1/0 and req_ready 0 on alternate cycles -> no lost or duplicated word; addr_d and dataW_d stable while stalled.
- Reset asserted mid-READ with 2 responses in flight -> all outputs 0 next cycle; late responses ignored; proto_err=0; a new command runs normally.
- Stray dataR_valid in IDLE -> proto_err=1, and it remains 1 until reset.
